vga_sync_decoder: RTL
=====================

VGA_SYNC_DECODER -- requirements
Module: vga_sync_decoder

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 Parameter H_TOTAL SHALL default to 800 and be the clocks per line.
REQ-003 Parameter V_TOTAL SHALL default to 525 and be the lines per frame.
REQ-004 Parameter H_START SHALL default to 144 and be the first active h_pos (sync 96 + back porch 48).
REQ-005 Parameter H_ACTIVE SHALL default to 640 and be the active pixels per line.
REQ-006 Parameter V_START SHALL default to 35 and be the first active v_pos (sync 2 + back porch 33).
REQ-007 Parameter V_ACTIVE SHALL default to 480 and be the active lines per frame.
REQ-008 Parameter LOCK_FRAMES SHALL default to 2 and be the consecutive good frames needed to lock.
REQ-009 Port CLK SHALL be an input, 1 bit: the pixel clock.
REQ-010 Port RST SHALL be an input, 1 bit: asynchronous, active-high reset.
REQ-011 Port VGA_HS SHALL be an input, 1 bit: horizontal sync, active-low, asynchronous.
REQ-012 Port VGA_VS SHALL be an input, 1 bit: vertical sync, active-low, asynchronous.
REQ-013 Port o_x SHALL be an output, 10 bits: active-region pixel column.
REQ-014 Port o_y SHALL be an output, 10 bits: active-region pixel row.
REQ-015 Port o_active SHALL be an output, 1 bit: o_x and o_y are valid.
REQ-016 Port o_locked SHALL be an output, 1 bit: sync timing is locked.
REQ-017 Port o_frame_start SHALL be an output, 1 bit: one-cycle pulse on each VS falling edge.
REQ-018 Port o_err_count SHALL be an output, 8 bits: saturating count of timing errors.

Function
REQ-019 VGA_HS and VGA_VS SHALL each pass through a 2-flop synchronizer, with falling edges detected on the synchronized value; a pin edge in cycle n SHALL take effect on the counters in cycle n+3.
REQ-020 The 10-bit h_pos SHALL clear on an HS fall, otherwise increment and saturate at 1023.
REQ-021 The 10-bit v_pos SHALL clear on a VS fall, otherwise increment on each HS fall; when both edges occur in the same cycle, clear SHALL win.
REQ-022 A line error SHALL be raised on an HS fall when h_pos+1 is not equal to H_TOTAL, except on the first HS fall after reset.
REQ-023 A frame error SHALL be raised on a VS fall when v_pos+1 is not equal to V_TOTAL, except on the first VS fall after reset.
REQ-024 A timeout error SHALL be raised once when h_pos reaches 1023, covering an HS stuck high or low.
REQ-025 o_err_count SHALL add 1 per error event, saturate at 255, and add only 1 when line and frame errors coincide in the same cycle.
REQ-026 The FSM states SHALL be SEARCH, ACQUIRE and LOCKED, with reset entering SEARCH.
REQ-027 SEARCH SHALL go to ACQUIRE on a VS fall, with good_frames = 0.
REQ-028 In ACQUIRE, at each VS fall, an error-free previous frame SHALL increment good_frames, and reaching LOCK_FRAMES SHALL move to LOCKED.
REQ-029 Any error in ACQUIRE SHALL clear good_frames and stay in ACQUIRE.
REQ-030 Any error in LOCKED SHALL go to SEARCH; a timeout from any state SHALL go to SEARCH.
REQ-031 o_locked SHALL be 1 only in LOCKED.
REQ-032 o_active SHALL be registered and equal to o_locked AND H_START <= h_pos < H_START+H_ACTIVE AND V_START <= v_pos < V_START+V_ACTIVE.
REQ-033 When o_active = 1, o_x SHALL equal h_pos - H_START and o_y SHALL equal v_pos - V_START, registered; otherwise both SHALL be 0.
REQ-034 o_frame_start SHALL pulse for 1 cycle, in the cycle v_pos clears, in every state.

Reset
REQ-035 Reset SHALL asynchronously set h_pos = 0, v_pos = 0, state = SEARCH, good_frames = 0, o_err_count = 0, o_x = 0, o_y = 0, o_active = 0, o_locked = 0, o_frame_start = 0, the synchronizer flops = 1, and the first-edge flags cleared.
REQ-036 Reset asserted mid-frame SHALL discard partial counts, and the first edges after release SHALL NOT raise errors.

Verification
REQ-037 Nominal 640x480 stimulus for 4 frames -> o_locked rises at the 3rd VS fall +3 clocks; o_err_count = 0.
REQ-038 Locked, first active pixel (h_pos 144, v_pos 35) -> o_active = 1, o_x = 0, o_y = 0 one cycle later; h_pos 783, v_pos 514 -> o_x = 639, o_y = 479.
REQ-039 Locked, one line shortened to 799 clocks -> o_err_count = 1, o_locked = 0 next cycle, relock after 2 further good frames.
REQ-040 VGA_HS held high 1100 clocks -> exactly 1 timeout error, state SEARCH, o_active = 0.
REQ-041 RST pulsed mid-frame while locked -> all outputs 0 immediately; the next VS fall raises no frame error.
REQ-042 Frame of 526 lines -> o_err_count increments by 1 at that VS fall; o_frame_start still pulses.

Source files
------------

// File: rtl/vga_sync_decoder.sv
// Recovers active-region pixel coordinates from asynchronous VGA HS/VS,
// tracks timing lock over whole frames and counts timing errors.
module vga_sync_decoder #(
  parameter int H_TOTAL     = 800,
  parameter int V_TOTAL     = 525,
  parameter int H_START     = 144,
  parameter int H_ACTIVE    = 640,
  parameter int V_START     = 35,
  parameter int V_ACTIVE    = 480,
  parameter int LOCK_FRAMES = 2
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       VGA_HS,
  input  logic       VGA_VS,
  output logic [9:0] o_x,
  output logic [9:0] o_y,
  output logic       o_active,
  output logic       o_locked,
  output logic       o_frame_start,
  output logic [7:0] o_err_count
);

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  localparam logic [10:0] H_TOTAL_C = 11'(H_TOTAL);
  localparam logic [10:0] V_TOTAL_C = 11'(V_TOTAL);
  localparam logic [10:0] H_LO_C    = 11'(H_START);
  localparam logic [10:0] H_HI_C    = 11'(H_START + H_ACTIVE);
  localparam logic [10:0] V_LO_C    = 11'(V_START);
  localparam logic [10:0] V_HI_C    = 11'(V_START + V_ACTIVE);
  localparam logic [7:0]  LOCK_C    = 8'(LOCK_FRAMES);

  logic [2:0]  hs_sync_r;
  logic [2:0]  vs_sync_r;
  logic        hs_fall_s;
  logic        vs_fall_s;
  logic [9:0]  h_pos_r;
  logic [9:0]  v_pos_r;
  logic [10:0] h_inc_s;
  logic [10:0] v_inc_s;
  logic        hs_seen_r;
  logic        vs_seen_r;
  logic        line_err_s;
  logic        frame_err_s;
  logic        timeout_s;
  logic        any_err_s;
  state_t      state_r;
  logic [7:0]  good_r;
  logic [7:0]  good_inc_s;
  logic        frame_ok_r;
  logic        active_s;

  // [0],[1] form the synchronizer; [2] holds the previous synchronized value
  assign hs_fall_s  = hs_sync_r[2] & ~hs_sync_r[1];
  assign vs_fall_s  = vs_sync_r[2] & ~vs_sync_r[1];
  assign h_inc_s    = {1'b0, h_pos_r} + 11'd1;
  assign v_inc_s    = {1'b0, v_pos_r} + 11'd1;
  assign good_inc_s = good_r + 8'd1;

  assign line_err_s  = hs_fall_s & hs_seen_r & (h_inc_s != H_TOTAL_C);
  assign frame_err_s = vs_fall_s & vs_seen_r & (v_inc_s != V_TOTAL_C);
  assign timeout_s   = ~hs_fall_s & (h_pos_r == 10'd1022);
  assign any_err_s   = line_err_s | frame_err_s | timeout_s;

  assign active_s = (state_r == LOCKED)
                  && ({1'b0, h_pos_r} >= H_LO_C) && ({1'b0, h_pos_r} < H_HI_C)
                  && ({1'b0, v_pos_r} >= V_LO_C) && ({1'b0, v_pos_r} < V_HI_C);

  // Sync input synchronizers and edge history
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      hs_sync_r <= 3'b111;
      vs_sync_r <= 3'b111;
    end else begin
      hs_sync_r <= {hs_sync_r[1:0], VGA_HS};
      vs_sync_r <= {vs_sync_r[1:0], VGA_VS};
    end
  end

  // Position counters, first-edge flags, frame pulse and error counter
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      h_pos_r       <= 10'd0;
      v_pos_r       <= 10'd0;
      hs_seen_r     <= 1'b0;
      vs_seen_r     <= 1'b0;
      o_frame_start <= 1'b0;
      o_err_count   <= 8'd0;
    end else begin
      if (hs_fall_s) begin
        h_pos_r <= 10'd0;
      end else if (h_pos_r != 10'd1023) begin
        h_pos_r <= h_pos_r + 10'd1;
      end
      if (vs_fall_s) begin
        v_pos_r <= 10'd0;
      end else if (hs_fall_s) begin
        v_pos_r <= v_pos_r + 10'd1;
      end
      hs_seen_r     <= hs_seen_r | hs_fall_s;
      vs_seen_r     <= vs_seen_r | vs_fall_s;
      o_frame_start <= vs_fall_s;
      // coincident line and frame errors count as a single event
      if (any_err_s && (o_err_count != 8'hFF)) begin
        o_err_count <= o_err_count + 8'd1;
      end
    end
  end

  // Lock state machine; frame_ok_r remembers whether the current frame saw an error
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r    <= SEARCH;
      good_r     <= 8'd0;
      frame_ok_r <= 1'b0;
      o_locked   <= 1'b0;
    end else if (timeout_s) begin
      state_r  <= SEARCH;
      good_r   <= 8'd0;
      o_locked <= 1'b0;
    end else begin
      case (state_r)
        SEARCH: begin
          if (vs_fall_s) begin
            state_r    <= ACQUIRE;
            good_r     <= 8'd0;
            frame_ok_r <= 1'b1;
          end
        end
        ACQUIRE: begin
          if (vs_fall_s) begin
            frame_ok_r <= 1'b1;
            if (any_err_s || !frame_ok_r) begin
              good_r <= 8'd0;
            end else if (good_inc_s >= LOCK_C) begin
              good_r   <= good_inc_s;
              state_r  <= LOCKED;
              o_locked <= 1'b1;
            end else begin
              good_r <= good_inc_s;
            end
          end else if (any_err_s) begin
            good_r     <= 8'd0;
            frame_ok_r <= 1'b0;
          end
        end
        LOCKED: begin
          if (any_err_s) begin
            state_r  <= SEARCH;
            good_r   <= 8'd0;
            o_locked <= 1'b0;
          end
        end
        default: begin
          state_r  <= SEARCH;
          good_r   <= 8'd0;
          o_locked <= 1'b0;
        end
      endcase
    end
  end

  // Registered coordinate outputs
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      o_active <= 1'b0;
      o_x      <= 10'd0;
      o_y      <= 10'd0;
    end else begin
      o_active <= active_s;
      o_x      <= active_s ? (h_pos_r - H_LO_C[9:0]) : 10'd0;
      o_y      <= active_s ? (v_pos_r - V_LO_C[9:0]) : 10'd0;
    end
  end

endmodule
